// File: rtl/qbus_pkg.sv
// Shared Q-bus master definitions: command encodings, sequencer states and
// register addresses of the peripherals sitting behind the 1801VP1-120 bridge.
package qbus_pkg;

  localparam logic [1:0] QB_OP_RD = 2'b00;
  localparam logic [1:0] QB_OP_WR = 2'b01;
  localparam logic [1:0] QB_OP_IA = 2'b10;

  typedef enum logic [2:0] {
    QB_IDLE,
    QB_ADDR,
    QB_SYNC,
    QB_DSET,
    QB_STRB,
    QB_HOLD,
    QB_TERM,
    QB_REL
  } qb_state_t;

  // Console terminal, parallel-port window and channel window registers
  localparam logic [15:0] QB_A_RCSR    = 16'o177560;
  localparam logic [15:0] QB_A_RBUF    = 16'o177562;
  localparam logic [15:0] QB_A_XCSR    = 16'o177564;
  localparam logic [15:0] QB_A_XBUF    = 16'o177566;
  localparam logic [15:0] QB_A_PP_BASE = 16'o176660;
  localparam logic [15:0] QB_A_PP_LAST = 16'o176676;
  localparam logic [15:0] QB_A_CH_BASE = 16'o177060;
  localparam logic [15:0] QB_A_CH_LAST = 16'o177100;

  // The reserved code runs as an ordinary read
  function automatic logic [1:0] qb_norm_op(input logic [1:0] op_in);
    return (op_in == 2'b11) ? QB_OP_RD : op_in;
  endfunction

endpackage

// File: rtl/qbus_sync2.sv
// Two-flop synchronizer for asynchronous active-low bus pins; idles high.
module qbus_sync2 (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_meta <= 1'b1;
      r_q    <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/qbus_mst.sv
// Q-bus initiator: turns one read/write/inta command into a strobe sequence,
// waits on the synchronized reply with a timeout and returns data and status.
module qbus_mst
  import qbus_pkg::*;
#(
  parameter int DW  = 16,
  parameter int TMO = 64,
  parameter int TW  = 8
) (
  input  logic          PIN_CLK,
  input  logic          PIN_nRST,
  input  logic          req,
  input  logic [1:0]    op,
  input  logic [DW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          busy,
  output logic          ack,
  output logic          err,
  output logic [DW-1:0] rdata,
  output logic [DW-1:0] ad_out,
  output logic          ad_oe,
  input  logic [DW-1:0] ad_in,
  output logic          nSYNC,
  output logic          nDIN,
  output logic          nDOUT,
  output logic          nIAKO,
  output logic          nCS,
  input  logic          nRPLY
);

  localparam logic [TW-1:0] TMO_LIM = TW'((TMO > 0) ? TMO - 1 : 0);

  qb_state_t     r_state, w_state_nxt;
  logic [1:0]    r_op;
  logic [DW-1:0] r_wdata;
  logic [TW-1:0] r_tmo_cnt, w_tmo_cnt_nxt;
  logic          w_rply_s;
  logic          w_tmo_hit;
  logic          w_tmo;

  logic          r_busy, r_ack, r_err, r_ad_oe;
  logic          r_nsync, r_ndin, r_ndout, r_niako, r_ncs;
  logic [DW-1:0] r_rdata, r_ad_out;
  logic          w_busy_nxt, w_ack_nxt, w_err_nxt, w_ad_oe_nxt;
  logic          w_nsync_nxt, w_ndin_nxt, w_ndout_nxt, w_niako_nxt, w_ncs_nxt;
  logic [DW-1:0] w_rdata_nxt, w_ad_out_nxt;

  qbus_sync2 u_rply_sync (
    .i_clk   (PIN_CLK),
    .i_rst_n (PIN_nRST),
    .i_d     (nRPLY),
    .o_q     (w_rply_s)
  );

  // Counter value lags the edge count by one, so the limit is TMO-1
  assign w_tmo_hit = (TMO != 0) && (r_tmo_cnt >= TMO_LIM);

  always_ff @(posedge PIN_CLK) begin
    if (!PIN_nRST) begin
      r_state   <= QB_IDLE;
      r_op      <= QB_OP_RD;
      r_tmo_cnt <= '0;
      r_busy    <= 1'b0;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_rdata   <= '0;
      r_ad_out  <= '0;
      r_ad_oe   <= 1'b0;
      r_nsync   <= 1'b1;
      r_ndin    <= 1'b1;
      r_ndout   <= 1'b1;
      r_niako   <= 1'b1;
      r_ncs     <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      if (r_state == QB_IDLE && req)
        r_op <= qb_norm_op(op);
      r_tmo_cnt <= w_tmo_cnt_nxt;
      r_busy    <= w_busy_nxt;
      r_ack     <= w_ack_nxt;
      r_err     <= w_err_nxt;
      r_rdata   <= w_rdata_nxt;
      r_ad_out  <= w_ad_out_nxt;
      r_ad_oe   <= w_ad_oe_nxt;
      r_nsync   <= w_nsync_nxt;
      r_ndin    <= w_ndin_nxt;
      r_ndout   <= w_ndout_nxt;
      r_niako   <= w_niako_nxt;
      r_ncs     <= w_ncs_nxt;
    end
  end

  always_ff @(posedge PIN_CLK) begin
    if (r_state == QB_IDLE && req)
      r_wdata <= wdata;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tmo       = 1'b0;
    case (r_state)
      QB_IDLE: if (req) w_state_nxt = QB_ADDR;
      QB_ADDR: w_state_nxt = QB_SYNC;
      QB_SYNC: w_state_nxt = (r_op == QB_OP_WR) ? QB_DSET : QB_STRB;
      QB_DSET: w_state_nxt = QB_STRB;
      QB_STRB: begin
        if (!w_rply_s) begin
          w_state_nxt = QB_HOLD;
        end else if (w_tmo_hit) begin
          w_state_nxt = QB_IDLE;
          w_tmo       = 1'b1;
        end
      end
      QB_HOLD: w_state_nxt = QB_TERM;
      QB_TERM: begin
        if (w_rply_s) begin
          w_state_nxt = QB_REL;
        end else if (w_tmo_hit) begin
          w_state_nxt = QB_IDLE;
          w_tmo       = 1'b1;
        end
      end
      QB_REL:  w_state_nxt = QB_IDLE;
      default: w_state_nxt = QB_IDLE;
    endcase
  end

  // Output registers are loaded with the values belonging to the state being entered
  always_comb begin
    w_busy_nxt    = r_busy;
    w_ack_nxt     = 1'b0;
    w_err_nxt     = 1'b0;
    w_rdata_nxt   = r_rdata;
    w_ad_out_nxt  = r_ad_out;
    w_ad_oe_nxt   = r_ad_oe;
    w_nsync_nxt   = r_nsync;
    w_ndin_nxt    = r_ndin;
    w_ndout_nxt   = r_ndout;
    w_niako_nxt   = r_niako;
    w_ncs_nxt     = r_ncs;
    w_tmo_cnt_nxt = r_tmo_cnt;

    if (r_state == QB_ADDR)
      w_tmo_cnt_nxt = '0;
    else if (r_state != QB_IDLE && r_state != QB_REL && r_tmo_cnt != '1)
      w_tmo_cnt_nxt = r_tmo_cnt + 1'b1;

    if (w_tmo) begin
      w_nsync_nxt = 1'b1;
      w_ndin_nxt  = 1'b1;
      w_ndout_nxt = 1'b1;
      w_niako_nxt = 1'b1;
      w_ncs_nxt   = 1'b1;
      w_ad_oe_nxt = 1'b0;
      w_busy_nxt  = 1'b0;
      w_ack_nxt   = 1'b1;
      w_err_nxt   = 1'b1;
    end else begin
      case (w_state_nxt)
        QB_ADDR: begin
          w_busy_nxt = 1'b1;
          if (qb_norm_op(op) == QB_OP_IA) begin
            w_ad_oe_nxt = 1'b0;
            w_ncs_nxt   = 1'b1;
          end else begin
            w_ad_oe_nxt  = 1'b1;
            w_ad_out_nxt = ~addr;
            w_ncs_nxt    = 1'b0;
          end
        end
        QB_SYNC: w_nsync_nxt = 1'b0;
        QB_DSET: w_ad_out_nxt = ~r_wdata;
        QB_STRB: begin
          case (r_op)
            QB_OP_WR: w_ndout_nxt = 1'b0;
            QB_OP_IA: begin
              w_ndin_nxt  = 1'b0;
              w_niako_nxt = 1'b0;
            end
            default: begin
              w_ad_oe_nxt = 1'b0;
              w_ndin_nxt  = 1'b0;
            end
          endcase
        end
        QB_HOLD: begin
          if (r_op != QB_OP_WR)
            w_rdata_nxt = ~ad_in;
          w_nsync_nxt = 1'b1;
          w_ndin_nxt  = 1'b1;
          w_ndout_nxt = 1'b1;
          w_niako_nxt = 1'b1;
        end
        QB_REL: begin
          w_ad_oe_nxt = 1'b0;
          w_ncs_nxt   = 1'b1;
          w_ack_nxt   = 1'b1;
          w_err_nxt   = 1'b0;
          w_busy_nxt  = 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy   = r_busy;
  assign ack    = r_ack;
  assign err    = r_err;
  assign rdata  = r_rdata;
  assign ad_out = r_ad_out;
  assign ad_oe  = r_ad_oe;
  assign nSYNC  = r_nsync;
  assign nDIN   = r_ndin;
  assign nDOUT  = r_ndout;
  assign nIAKO  = r_niako;
  assign nCS    = r_ncs;

endmodule

// File: tb/tb_qbus_mst.sv
// Bench for qbus_mst: a behavioural responder with programmable reply delays
// plus a timeline model of command latency, status and returned data.
module tb_qbus_mst;
  import qbus_pkg::*;

  localparam int DW  = 16;
  localparam int TMO = 16;
  localparam int TW  = 8;
  localparam int MAXC = 48;

  logic          PIN_CLK = 1'b0;
  logic          PIN_nRST;
  logic          req;
  logic [1:0]    op;
  logic [DW-1:0] addr, wdata;
  logic          busy, ack, err;
  logic [DW-1:0] rdata, ad_out, ad_in;
  logic          ad_oe;
  logic          nSYNC, nDIN, nDOUT, nIAKO, nCS;
  logic          nRPLY;

  int n_vec = 0;
  int n_bad = 0;

  logic          rsp_en;
  int            rsp_df, rsp_dr;
  logic [15:0]   rsp_data;
  logic [15:0]   exp_rdata;

  logic [15:0] s_ad_out [MAXC];
  logic        s_oe [MAXC], s_ncs [MAXC], s_busy [MAXC];
  logic        s_nsync [MAXC], s_ndin [MAXC], s_ndout [MAXC], s_niako [MAXC];

  logic [15:0] addr_tab [6] = '{QB_A_RCSR, QB_A_RBUF, QB_A_XCSR, QB_A_XBUF,
                                QB_A_PP_BASE, QB_A_CH_LAST};

  always #5 PIN_CLK = ~PIN_CLK;

  qbus_mst #(.DW(DW), .TMO(TMO), .TW(TW)) dut (
    .PIN_CLK  (PIN_CLK),
    .PIN_nRST (PIN_nRST),
    .req      (req),
    .op       (op),
    .addr     (addr),
    .wdata    (wdata),
    .busy     (busy),
    .ack      (ack),
    .err      (err),
    .rdata    (rdata),
    .ad_out   (ad_out),
    .ad_oe    (ad_oe),
    .ad_in    (ad_in),
    .nSYNC    (nSYNC),
    .nDIN     (nDIN),
    .nDOUT    (nDOUT),
    .nIAKO    (nIAKO),
    .nCS      (nCS),
    .nRPLY    (nRPLY)
  );

  // Responder: data is on the bus while nDIN is low; reply edges lag strobes
  assign ad_in = (!nDIN) ? ~rsp_data : 16'hFFFF;

  initial begin
    int f_cnt, r_cnt;
    nRPLY = 1'b1;
    f_cnt = 0;
    r_cnt = 0;
    forever begin
      @(posedge PIN_CLK);
      #1;
      if (!rsp_en) begin
        nRPLY = 1'b1;
        f_cnt = 0;
        r_cnt = 0;
      end else if (!nDIN || !nDOUT) begin
        r_cnt = 0;
        if (nRPLY) begin
          if (f_cnt >= rsp_df) nRPLY = 1'b0;
          else f_cnt++;
        end
      end else begin
        f_cnt = 0;
        if (!nRPLY) begin
          if (r_cnt >= rsp_dr) nRPLY = 1'b1;
          else r_cnt++;
        end
      end
    end
  end

  task automatic snap(input int k);
    s_ad_out[k] = ad_out;
    s_oe[k]     = ad_oe;
    s_ncs[k]    = nCS;
    s_busy[k]   = busy;
    s_nsync[k]  = nSYNC;
    s_ndin[k]   = nDIN;
    s_ndout[k]  = nDOUT;
    s_niako[k]  = nIAKO;
  endtask

  // Issues one command and records pins after every edge; index 0 is the accept edge
  task automatic run_cmd(input logic [1:0] c_op, input logic [15:0] c_addr,
                         input logic [15:0] c_wdata, output int ack_at, output logic err_o);
    @(posedge PIN_CLK); #1;
    req = 1'b1; op = c_op; addr = c_addr; wdata = c_wdata;
    @(posedge PIN_CLK); #1;
    req = 1'b0;
    snap(0);
    ack_at = -1;
    err_o  = 1'bx;
    for (int k = 1; k < MAXC; k++) begin
      @(posedge PIN_CLK); #1;
      snap(k);
      if (ack === 1'b1) begin
        ack_at = k;
        err_o  = err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    PIN_nRST = 1'b0;
    repeat (3) @(posedge PIN_CLK);
    #1;
    n_vec++; if ({nSYNC, nDIN, nDOUT, nIAKO, nCS} !== 5'b11111) begin n_bad++;
      $display("FAIL rst_strobes: got %b expected 11111", {nSYNC, nDIN, nDOUT, nIAKO, nCS}); end
    n_vec++; if ({ad_oe, busy, ack, err} !== 4'b0000) begin n_bad++;
      $display("FAIL rst_ctrl: got %b expected 0000", {ad_oe, busy, ack, err}); end
    n_vec++; if (ad_out !== 16'h0000) begin n_bad++;
      $display("FAIL rst_ad_out: got %h expected 0000", ad_out); end
    n_vec++; if (rdata !== exp_rdata) begin n_bad++;
      $display("FAIL rst_rdata: got %h expected %h", rdata, exp_rdata); end
    PIN_nRST = 1'b1;
  endtask

  task automatic test_write();
    int at; logic e;
    logic [15:0] a, w;
    a = QB_A_XCSR; w = 16'o000100;
    rsp_en = 1'b1; rsp_df = 0; rsp_dr = 0;
    run_cmd(QB_OP_WR, a, w, at, e);
    n_vec++; if ({s_busy[0], s_oe[0], s_ncs[0]} !== 3'b110) begin n_bad++;
      $display("FAIL wr_addr_phase: got busy/oe/ncs %b expected 110", {s_busy[0], s_oe[0], s_ncs[0]}); end
    n_vec++; if (s_ad_out[0] !== ~a) begin n_bad++;
      $display("FAIL wr_ad_addr: got %h expected %h", s_ad_out[0], ~a); end
    n_vec++; if (s_nsync[1] !== 1'b0) begin n_bad++;
      $display("FAIL wr_nsync: got %b expected 0", s_nsync[1]); end
    n_vec++; if (s_ad_out[2] !== ~w) begin n_bad++;
      $display("FAIL wr_ad_data: got %h expected %h", s_ad_out[2], ~w); end
    n_vec++; if ({s_ndout[2], s_ndout[3]} !== 2'b10) begin n_bad++;
      $display("FAIL wr_ndout_after_dset: got %b expected 10", {s_ndout[2], s_ndout[3]}); end
    n_vec++; if (at !== 9) begin n_bad++;
      $display("FAIL wr_ack_clock: got %0d expected 9", at); end
    n_vec++; if (e !== 1'b0) begin n_bad++;
      $display("FAIL wr_err: got %b expected 0", e); end
    n_vec++; if (rdata !== exp_rdata) begin n_bad++;
      $display("FAIL wr_rdata_kept: got %h expected %h", rdata, exp_rdata); end
  endtask

  task automatic test_read();
    int at; logic e; logic oe_seen;
    rsp_en = 1'b1; rsp_df = 3; rsp_dr = 0; rsp_data = 16'o000101;
    run_cmd(QB_OP_RD, QB_A_RBUF, 16'h0000, at, e);
    exp_rdata = rsp_data;
    oe_seen = 1'b0;
    for (int k = 2; k <= at && k < MAXC; k++) oe_seen |= s_oe[k];
    n_vec++; if ({s_ndin[2], oe_seen} !== 2'b00) begin n_bad++;
      $display("FAIL rd_strobe_phase: got ndin/oe %b expected 00", {s_ndin[2], oe_seen}); end
    n_vec++; if (at !== 11) begin n_bad++;
      $display("FAIL rd_ack_clock: got %0d expected 11", at); end
    n_vec++; if (e !== 1'b0) begin n_bad++;
      $display("FAIL rd_err: got %b expected 0", e); end
    n_vec++; if (rdata !== exp_rdata) begin n_bad++;
      $display("FAIL rd_data: got %o expected %o", rdata, exp_rdata); end
  endtask

  task automatic test_inta();
    int at; logic e; logic ncs_all, oe_any;
    rsp_en = 1'b1; rsp_df = 0; rsp_dr = 0; rsp_data = 16'o000060;
    run_cmd(QB_OP_IA, 16'($urandom), 16'h0000, at, e);
    exp_rdata = rsp_data;
    ncs_all = 1'b1; oe_any = 1'b0;
    for (int k = 0; k <= at && k < MAXC; k++) begin
      ncs_all &= s_ncs[k];
      oe_any  |= s_oe[k];
    end
    n_vec++; if ({ncs_all, oe_any} !== 2'b10) begin n_bad++;
      $display("FAIL ia_bus_idle: got ncs_all/oe_any %b expected 10", {ncs_all, oe_any}); end
    n_vec++; if ({s_niako[2], s_ndin[2]} !== 2'b00) begin n_bad++;
      $display("FAIL ia_strobes: got niako/ndin %b expected 00", {s_niako[2], s_ndin[2]}); end
    n_vec++; if (at !== 8 || e !== 1'b0) begin n_bad++;
      $display("FAIL ia_ack: got clock %0d err %b expected clock 8 err 0", at, e); end
    n_vec++; if (rdata !== exp_rdata) begin n_bad++;
      $display("FAIL ia_vector: got %o expected %o", rdata, exp_rdata); end
  endtask

  task automatic test_timeout();
    int at; logic e; int fall, rise;
    rsp_en = 1'b0; rsp_data = 16'o123456;
    run_cmd(QB_OP_RD, QB_A_RCSR, 16'h0000, at, e);
    fall = -1; rise = -1;
    for (int k = 0; k < MAXC && k <= at; k++) begin
      if (fall < 0 && s_nsync[k] === 1'b0) fall = k;
      if (fall >= 0 && rise < 0 && s_nsync[k] === 1'b1) rise = k;
    end
    n_vec++; if (rise - fall !== TMO || fall < 0) begin n_bad++;
      $display("FAIL tmo_release: got %0d clocks expected %0d", rise - fall, TMO); end
    n_vec++; if (at !== 1 + TMO || e !== 1'b1) begin n_bad++;
      $display("FAIL tmo_ack: got clock %0d err %b expected clock %0d err 1", at, e, 1 + TMO); end
    n_vec++; if (at > 0 && {s_nsync[at], s_ndin[at], s_ncs[at], s_oe[at], s_busy[at]} !== 5'b11100) begin n_bad++;
      $display("FAIL tmo_pins: got %b expected 11100", {s_nsync[at], s_ndin[at], s_ncs[at], s_oe[at], s_busy[at]}); end
    n_vec++; if (rdata !== exp_rdata) begin n_bad++;
      $display("FAIL tmo_rdata_kept: got %h expected %h", rdata, exp_rdata); end
  endtask

  task automatic test_back_to_back();
    int k1, k2; logic e1, e2;
    logic [15:0] a1, a2, w1;
    a1 = QB_A_XBUF; a2 = QB_A_CH_BASE; w1 = 16'($urandom);
    rsp_en = 1'b1; rsp_df = 0; rsp_dr = 0; rsp_data = 16'($urandom);
    @(posedge PIN_CLK); #1;
    req = 1'b1; op = QB_OP_WR; addr = a1; wdata = w1;
    @(posedge PIN_CLK); #1;
    op = QB_OP_RD; addr = a2; wdata = ~w1;
    k1 = -1; e1 = 1'bx;
    for (int k = 1; k < MAXC; k++) begin
      @(posedge PIN_CLK); #1;
      if (k == 2) begin
        n_vec++; if (ad_out !== ~w1) begin n_bad++;
          $display("FAIL b2b_wdata_latched: got %h expected %h", ad_out, ~w1); end
      end
      if (ack === 1'b1) begin k1 = k; e1 = err; break; end
    end
    n_vec++; if (k1 !== 9 || e1 !== 1'b0) begin n_bad++;
      $display("FAIL b2b_first_ack: got clock %0d err %b expected clock 9 err 0", k1, e1); end
    @(posedge PIN_CLK); #1;
    n_vec++; if ({busy, nCS} !== 2'b01) begin n_bad++;
      $display("FAIL b2b_idle_gap: got busy/ncs %b expected 01", {busy, nCS}); end
    @(posedge PIN_CLK); #1;
    req = 1'b0;
    n_vec++; if ({busy, nCS} !== 2'b10 || ad_out !== ~a2) begin n_bad++;
      $display("FAIL b2b_second_addr: got busy/ncs %b ad %h expected 10 ad %h", {busy, nCS}, ad_out, ~a2); end
    k2 = -1; e2 = 1'bx;
    for (int k = 1; k < MAXC; k++) begin
      @(posedge PIN_CLK); #1;
      if (ack === 1'b1) begin k2 = k; e2 = err; break; end
    end
    exp_rdata = rsp_data;
    n_vec++; if (k2 !== 8 || e2 !== 1'b0) begin n_bad++;
      $display("FAIL b2b_second_ack: got clock %0d err %b expected clock 8 err 0", k2, e2); end
    n_vec++; if (rdata !== exp_rdata) begin n_bad++;
      $display("FAIL b2b_rdata: got %h expected %h", rdata, exp_rdata); end
  endtask

  task automatic test_random();
    int at, exp_at; logic e;
    logic [1:0] c_op; logic [15:0] a, w;
    bit is_wr, is_ia;
    for (int i = 0; i < 30; i++) begin
      c_op     = 2'($urandom_range(0, 3));
      a        = ($urandom_range(0, 1) == 0) ? addr_tab[$urandom_range(0, 5)] : 16'($urandom);
      w        = 16'($urandom);
      rsp_data = 16'($urandom);
      rsp_df   = $urandom_range(0, 3);
      rsp_dr   = $urandom_range(0, 3);
      rsp_en   = ($urandom_range(0, 7) != 0);
      is_wr    = (c_op == 2'b01);
      is_ia    = (c_op == 2'b10);
      // Round trip: 2 sync flops each way plus the fixed states; write adds DSET
      exp_at = !rsp_en ? 1 + TMO : (is_wr ? 9 : 8) + rsp_df + rsp_dr;
      run_cmd(c_op, a, w, at, e);
      if (rsp_en && !is_wr) exp_rdata = rsp_data;
      n_vec++; if (at !== exp_at || e !== !rsp_en) begin n_bad++;
        $display("FAIL rnd_ack[%0d]: got clock %0d err %b expected clock %0d err %b", i, at, e, exp_at, !rsp_en); end
      n_vec++; if (rdata !== exp_rdata) begin n_bad++;
        $display("FAIL rnd_rdata[%0d]: got %h expected %h", i, rdata, exp_rdata); end
      n_vec++; if (s_ncs[0] !== is_ia || s_oe[0] !== !is_ia || (!is_ia && s_ad_out[0] !== ~a)) begin n_bad++;
        $display("FAIL rnd_addr[%0d]: got ncs %b oe %b ad %h expected ncs %b addr %h", i, s_ncs[0], s_oe[0], s_ad_out[0], is_ia, ~a); end
    end
  endtask

  task automatic test_reset_midcycle();
    logic ack_seen, busy_seen;
    rsp_en = 1'b0;
    @(posedge PIN_CLK); #1;
    req = 1'b1; op = QB_OP_RD; addr = QB_A_PP_LAST;
    @(posedge PIN_CLK); #1;
    req = 1'b0;
    repeat (2) @(posedge PIN_CLK);
    #1;
    n_vec++; if (nDIN !== 1'b0) begin n_bad++;
      $display("FAIL midrst_in_strb: got ndin %b expected 0", nDIN); end
    PIN_nRST = 1'b0;
    @(posedge PIN_CLK); #1;
    exp_rdata = 16'h0000;
    n_vec++; if ({nSYNC, nDIN, nDOUT, nIAKO, nCS, ad_oe, busy, ack} !== 8'b11111000) begin n_bad++;
      $display("FAIL midrst_pins: got %b expected 11111000", {nSYNC, nDIN, nDOUT, nIAKO, nCS, ad_oe, busy, ack}); end
    PIN_nRST = 1'b1;
    ack_seen = 1'b0; busy_seen = 1'b0;
    for (int k = 0; k < 24; k++) begin
      @(posedge PIN_CLK); #1;
      ack_seen  |= ack;
      busy_seen |= busy;
    end
    n_vec++; if ({ack_seen, busy_seen} !== 2'b00) begin n_bad++;
      $display("FAIL midrst_no_ack: got ack/busy seen %b expected 00", {ack_seen, busy_seen}); end
    n_vec++; if (rdata !== exp_rdata) begin n_bad++;
      $display("FAIL midrst_rdata: got %h expected %h", rdata, exp_rdata); end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    PIN_nRST  = 1'b0;
    req       = 1'b0;
    op        = 2'b00;
    addr      = '0;
    wdata     = '0;
    rsp_en    = 1'b0;
    rsp_df    = 0;
    rsp_dr    = 0;
    rsp_data  = '0;
    exp_rdata = '0;
    test_reset();
    test_write();
    test_read();
    test_inta();
    test_timeout();
    test_back_to_back();
    test_random();
    test_reset_midcycle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
